// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH unsigned multiplier. It performs one
// partial-product step per clock and relies on an external WIDTH-bit add/sub
// unit for every step. Each RUN cycle this block drives the adder with the
// upper accumulator half and, when the current multiplier bit is set, the
// multiplicand. On the clock edge it takes the adder's sum and carryout and
// shifts the whole accumulator right by one bit.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   start         multiply request, accepted only in IDLE or DONE
//   op_a / op_b   multiplicand / multiplier, captured on an accepted start
//   busy          high while iterating (RUN)
//   done          one-cycle pulse in the cycle product becomes valid
//   product       registered result, held until the next result or reset
//   add_a, add_b  operands driven to the external adder (0 outside RUN)
//   add_carryin   adder carry-in / subtract select, always 0
//   add_slt       adder set-less-than select, always 0
//   add_sum       adder sum returned to this block
//   add_carryout  adder carryout returned to this block
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_carryin,
    output logic                 add_slt,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_carryout
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // The adder result, with its carryout as the extra top bit, concatenated
    // with the still-unconsumed multiplier bits. This is the accumulator after
    // the shift-right step.
    logic [2*WIDTH-1:0]   acc_shifted;
    logic                 last_iter;

    assign acc_shifted = {add_carryout, add_sum, acc_lo_q[WIDTH-1:1]};
    assign last_iter   = (count_q == CNT_W'(ITER - 1));

    // This block only adds. Subtraction and the slt path are never enabled.
    assign add_carryin = 1'b0;
    assign add_slt     = 1'b0;

    assign product     = product_q;

    always_comb begin
        // NOTE: every signal written here gets a default first. A branch that
        // skips an assignment would otherwise infer a latch.
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        count_d   = count_q;
        product_d = product_q;
        add_a     = '0;
        add_b     = '0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    acc_hi_d = '0;
                    acc_lo_d = op_b;
                    count_d  = '0;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                busy     = 1'b1;
                add_a    = acc_hi_q;
                // The LSB of acc_lo is the multiplier bit that the current
                // step consumes.
                add_b    = acc_lo_q[0] ? mcand_q : '0;
                acc_hi_d = acc_shifted[2*WIDTH-1:WIDTH];
                acc_lo_d = acc_shifted[WIDTH-1:0];
                count_d  = count_q + CNT_W'(1);
                if (last_iter) begin
                    // The result is registered on the final step so that it
                    // is already valid in the DONE cycle.
                    product_d = acc_shifted;
                    state_d   = S_DONE;
                end
            end

            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    mcand_d  = op_a;
                    acc_hi_d = '0;
                    acc_lo_d = op_b;
                    count_d  = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every
        // register samples pre-edge values, whatever order the statements are in.
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

endmodule
